// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipelined microcontroller main controller.
package hazard_controller_pkg;

  typedef enum logic [2:0] {LD, OUT, ADD, SUB, NAND, NOR, XOR, SHFL} t_opcode;

  typedef enum logic {takeGPR, takeIMM} t_ALUsrc_ctrl;

  localparam int unsigned REG_NAME_W         = 8;
  localparam int unsigned DEFAULT_PIPE_DEPTH = 3;

  typedef logic [REG_NAME_W-1:0] t_reg_name;

  // True when idx names an implemented general-purpose register.
  function automatic logic is_gpr_idx(input t_reg_name idx, input int unsigned num_gpr);
    return 32'(idx) < num_gpr;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Instruction-in / EX-control-out bundle of the hazard controller.
interface hazard_controller_if #(
  parameter int unsigned REG_W = 2
);
  import hazard_controller_pkg::*;

  t_opcode            opcode;
  logic               instv;
  logic [REG_W-1:0]   dst;
  logic [REG_W-1:0]   src1;
  logic               src1_imm;
  logic [REG_W-1:0]   src2;
  logic               src2_imm;

  logic               internal_reset;
  logic               issue_v;
  t_ALUsrc_ctrl       ALUsrc1;
  t_ALUsrc_ctrl       ALUsrc2;
  t_opcode            ALUop;
  logic               wr_en;
  logic [REG_W-1:0]   wr_addr;
  logic               dataoutv;
  logic               fwd1;
  logic               fwd2;
  logic               stalled;
  logic               illegal;

  modport master (
    output opcode, instv, dst, src1, src1_imm, src2, src2_imm,
    input  internal_reset, issue_v, ALUsrc1, ALUsrc2, ALUop, wr_en, wr_addr,
           dataoutv, fwd1, fwd2, stalled, illegal
  );

  modport slave (
    input  opcode, instv, dst, src1, src1_imm, src2, src2_imm,
    output internal_reset, issue_v, ALUsrc1, ALUsrc2, ALUop, wr_en, wr_addr,
           dataoutv, fwd1, fwd2, stalled, illegal
  );

endinterface

// File: rtl/hazard_controller_reg_scoreboard.sv
// Per-GPR countdown of cycles until a pending result is readable from the RF.
module hazard_controller_reg_scoreboard
  import hazard_controller_pkg::*;
#(
  parameter  int unsigned NUM_GPR    = 4,
  parameter  int unsigned PIPE_DEPTH = DEFAULT_PIPE_DEPTH,
  localparam int unsigned REG_W      = $clog2(NUM_GPR)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [REG_W-1:0] load_idx,
  input  logic [REG_W-1:0] rd1_idx,
  input  logic [REG_W-1:0] rd2_idx,
  output logic             rd1_busy_c,
  output logic             rd1_last_c,
  output logic             rd2_busy_c,
  output logic             rd2_last_c
);

  localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 1);

  typedef logic [CNT_W-1:0] t_cnt;

  t_cnt busy_q [NUM_GPR];
  t_cnt rd1_cnt;
  t_cnt rd2_cnt;

  // A load overrides the decrement, so a WAW simply restarts the countdown.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_GPR; r++) busy_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_GPR; r++) begin
        if (load_en && load_idx == REG_W'(r)) busy_q[r] <= CNT_W'(PIPE_DEPTH);
        else if (busy_q[r] != '0)              busy_q[r] <= busy_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd1_cnt = '0;
    rd2_cnt = '0;
    for (int unsigned r = 0; r < NUM_GPR; r++) begin
      if (rd1_idx == REG_W'(r)) rd1_cnt = busy_q[r];
      if (rd2_idx == REG_W'(r)) rd2_cnt = busy_q[r];
    end
  end

  assign rd1_busy_c = (rd1_cnt != '0);
  assign rd1_last_c = (rd1_cnt == CNT_W'(1));
  assign rd2_busy_c = (rd2_cnt != '0);
  assign rd2_last_c = (rd2_cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_controller.sv
// Main controller: decode, legality, RAW-hazard issue control and EX-stage
// control registers for the pipelined microcontroller.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned NUM_GPR    = 4,
  parameter int unsigned PIPE_DEPTH = DEFAULT_PIPE_DEPTH,
  parameter int unsigned BYPASS_EN  = 0
) (
  input logic                clock,
  input logic                reset_n,
  hazard_controller_if.slave bus
);

  localparam int unsigned REG_W = $clog2(NUM_GPR);
  localparam bit          BYP   = (BYPASS_EN != 0);

  logic             int_rst_q;
  logic             writes_c, use1_c, use2_c, legal_c;
  logic             busy1_c, last1_c, busy2_c, last2_c;
  logic             haz_c, fwd1_c, fwd2_c;
  logic             accept_c, illegal_c;

  logic             issue_v_q, wr_en_q, dataoutv_q, fwd1_q, fwd2_q, illegal_q;
  t_ALUsrc_ctrl     alusrc1_q, alusrc2_q;
  t_opcode          aluop_q;
  logic [REG_W-1:0] wr_addr_q;

  // Held for one edge after reset release so deassertion is clock-aligned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) int_rst_q <= 1'b1;
    else          int_rst_q <= 1'b0;
  end

  // Operand usage and legality decode.
  always_comb begin
    writes_c = 1'b0;
    use1_c   = 1'b0;
    use2_c   = 1'b0;
    legal_c  = 1'b1;
    case (bus.opcode)
      LD:  begin
        writes_c = 1'b1;
        legal_c  = bus.src1_imm;
      end
      OUT: begin
        use1_c  = 1'b1;
        legal_c = ~bus.src1_imm;
      end
      ADD, SUB, NAND, NOR, XOR, SHFL: begin
        writes_c = 1'b1;
        use1_c   = ~bus.src1_imm;
        use2_c   = ~bus.src2_imm;
      end
      default: legal_c = 1'b0;
    endcase
    if (writes_c && !is_gpr_idx(t_reg_name'(bus.dst), NUM_GPR))  legal_c = 1'b0;
    if (use1_c   && !is_gpr_idx(t_reg_name'(bus.src1), NUM_GPR)) legal_c = 1'b0;
    if (use2_c   && !is_gpr_idx(t_reg_name'(bus.src2), NUM_GPR)) legal_c = 1'b0;
  end

  hazard_controller_reg_scoreboard #(
    .NUM_GPR    (NUM_GPR),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_reg_scoreboard (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_en    (accept_c & writes_c),
    .load_idx   (bus.dst),
    .rd1_idx    (bus.src1),
    .rd2_idx    (bus.src2),
    .rd1_busy_c (busy1_c),
    .rd1_last_c (last1_c),
    .rd2_busy_c (busy2_c),
    .rd2_last_c (last2_c)
  );

  // With bypass, a producer one cycle from RF write is forwarded, not waited on.
  always_comb begin
    fwd1_c = use1_c & BYP & last1_c;
    fwd2_c = use2_c & BYP & last2_c;
    haz_c  = (use1_c & busy1_c & ~fwd1_c) | (use2_c & busy2_c & ~fwd2_c);
  end

  assign accept_c  = bus.instv &  legal_c & ~haz_c & ~int_rst_q;
  assign illegal_c = bus.instv & ~legal_c & ~int_rst_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue_v_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      dataoutv_q <= 1'b0;
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
      illegal_q  <= 1'b0;
      alusrc1_q  <= takeGPR;
      alusrc2_q  <= takeGPR;
      aluop_q    <= LD;
      wr_addr_q  <= '0;
    end else begin
      issue_v_q  <= accept_c;
      wr_en_q    <= accept_c & writes_c;
      dataoutv_q <= accept_c & (bus.opcode == OUT);
      fwd1_q     <= accept_c & fwd1_c;
      fwd2_q     <= accept_c & fwd2_c;
      illegal_q  <= illegal_c;
      if (accept_c) begin
        alusrc1_q <= bus.src1_imm ? takeIMM : takeGPR;
        alusrc2_q <= bus.src2_imm ? takeIMM : takeGPR;
        aluop_q   <= bus.opcode;
        wr_addr_q <= bus.dst;
      end
    end
  end

  assign bus.internal_reset = int_rst_q;
  assign bus.stalled        = bus.instv & legal_c & haz_c & ~int_rst_q;
  assign bus.issue_v        = issue_v_q;
  assign bus.wr_en          = wr_en_q;
  assign bus.dataoutv       = dataoutv_q;
  assign bus.fwd1           = fwd1_q;
  assign bus.fwd2           = fwd2_q;
  assign bus.illegal        = illegal_q;
  assign bus.ALUsrc1        = alusrc1_q;
  assign bus.ALUsrc2        = alusrc2_q;
  assign bus.ALUop          = aluop_q;
  assign bus.wr_addr        = wr_addr_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: three controllers (no bypass, bypass, 3 GPRs) share one stimulus stream.
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  t_opcode    opcode  = LD;
  logic       instv   = 1'b0;
  logic [1:0] dst     = '0;
  logic [1:0] src1    = '0;
  logic       src1_imm = 1'b0;
  logic [1:0] src2    = '0;
  logic       src2_imm = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_controller_if #(.REG_W(2)) bus_a ();
  hazard_controller_if #(.REG_W(2)) bus_b ();
  hazard_controller_if #(.REG_W(2)) bus_c ();

  assign bus_a.opcode = opcode;  assign bus_b.opcode = opcode;  assign bus_c.opcode = opcode;
  assign bus_a.instv = instv;    assign bus_b.instv = instv;    assign bus_c.instv = instv;
  assign bus_a.dst = dst;        assign bus_b.dst = dst;        assign bus_c.dst = dst;
  assign bus_a.src1 = src1;      assign bus_b.src1 = src1;      assign bus_c.src1 = src1;
  assign bus_a.src1_imm = src1_imm; assign bus_b.src1_imm = src1_imm; assign bus_c.src1_imm = src1_imm;
  assign bus_a.src2 = src2;      assign bus_b.src2 = src2;      assign bus_c.src2 = src2;
  assign bus_a.src2_imm = src2_imm; assign bus_b.src2_imm = src2_imm; assign bus_c.src2_imm = src2_imm;

  hazard_controller #(.NUM_GPR(4), .PIPE_DEPTH(3), .BYPASS_EN(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  hazard_controller #(.NUM_GPR(4), .PIPE_DEPTH(3), .BYPASS_EN(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));
  hazard_controller #(.NUM_GPR(3), .PIPE_DEPTH(3), .BYPASS_EN(0)) dut_c (
    .clock(clock), .reset_n(reset_n), .bus(bus_c));

  always #5 clock = ~clock;

  task automatic set_instr(input t_opcode op, input logic [1:0] d, input logic [1:0] s1,
                           input logic s1i, input logic [1:0] s2, input logic s2i);
    opcode = op; dst = d; src1 = s1; src1_imm = s1i; src2 = s2; src2_imm = s2i;
    instv = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    instv   = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_checks++; if (bus_a.internal_reset !== 1'b1) begin n_fail++; $display("FAIL rst_internal_reset got %0b exp 1", bus_a.internal_reset); end
    n_checks++; if (bus_a.issue_v !== 1'b0) begin n_fail++; $display("FAIL rst_issue_v got %0b exp 0", bus_a.issue_v); end
    n_checks++; if (bus_a.wr_en !== 1'b0 || bus_a.dataoutv !== 1'b0) begin n_fail++; $display("FAIL rst_wr_dataoutv got %0b%0b exp 00", bus_a.wr_en, bus_a.dataoutv); end
    n_checks++; if (bus_a.illegal !== 1'b0 || bus_a.fwd1 !== 1'b0 || bus_a.fwd2 !== 1'b0) begin n_fail++; $display("FAIL rst_ill_fwd got %0b%0b%0b exp 000", bus_a.illegal, bus_a.fwd1, bus_a.fwd2); end
    n_checks++; if (bus_a.ALUop !== LD || bus_a.wr_addr !== 2'd0) begin n_fail++; $display("FAIL rst_aluop_wraddr got %0d/%0d exp 0/0", bus_a.ALUop, bus_a.wr_addr); end
    n_checks++; if (bus_a.ALUsrc1 !== takeGPR || bus_a.ALUsrc2 !== takeGPR) begin n_fail++; $display("FAIL rst_alusrc got %0d/%0d exp 0/0", bus_a.ALUsrc1, bus_a.ALUsrc2); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    set_instr(ADD, 2'd1, 2'd0, 1'b0, 2'd0, 1'b1);
    #1;
    n_checks++; if (bus_a.internal_reset !== 1'b1) begin n_fail++; $display("FAIL rel_internal_reset_held got %0b exp 1", bus_a.internal_reset); end
    n_checks++; if (bus_a.stalled !== 1'b0) begin n_fail++; $display("FAIL rel_stalled got %0b exp 0", bus_a.stalled); end
    tick();
    n_checks++; if (bus_a.issue_v !== 1'b0) begin n_fail++; $display("FAIL rel_edge1_issue_v got %0b exp 0", bus_a.issue_v); end
    n_checks++; if (bus_a.internal_reset !== 1'b0) begin n_fail++; $display("FAIL rel_edge1_internal_reset got %0b exp 0", bus_a.internal_reset); end
    tick();
    n_checks++; if (bus_a.issue_v !== 1'b1 || bus_a.wr_addr !== 2'd1 || bus_a.wr_en !== 1'b1) begin n_fail++; $display("FAIL rel_edge2_issue got v=%0b a=%0d w=%0b exp v=1 a=1 w=1", bus_a.issue_v, bus_a.wr_addr, bus_a.wr_en); end
    instv = 1'b0;
  endtask

  task automatic test_independent();
    do_reset();
    set_instr(ADD, 2'd1, 2'd0, 1'b0, 2'd0, 1'b1);
    #1;
    n_checks++; if (bus_a.stalled !== 1'b0) begin n_fail++; $display("FAIL ind_add_stalled got %0b exp 0", bus_a.stalled); end
    tick();
    n_checks++; if (bus_a.issue_v !== 1'b1 || bus_a.wr_addr !== 2'd1 || bus_a.ALUop !== ADD) begin n_fail++; $display("FAIL ind_add_issue got v=%0b a=%0d op=%0d exp v=1 a=1 op=2", bus_a.issue_v, bus_a.wr_addr, bus_a.ALUop); end
    n_checks++; if (bus_a.ALUsrc1 !== takeGPR || bus_a.ALUsrc2 !== takeIMM) begin n_fail++; $display("FAIL ind_add_alusrc got %0d/%0d exp 0/1", bus_a.ALUsrc1, bus_a.ALUsrc2); end
    set_instr(SUB, 2'd2, 2'd3, 1'b0, 2'd0, 1'b1);
    #1;
    n_checks++; if (bus_a.stalled !== 1'b0) begin n_fail++; $display("FAIL ind_sub_stalled got %0b exp 0", bus_a.stalled); end
    tick();
    n_checks++; if (bus_a.issue_v !== 1'b1 || bus_a.wr_addr !== 2'd2 || bus_a.ALUop !== SUB) begin n_fail++; $display("FAIL ind_sub_issue got v=%0b a=%0d op=%0d exp v=1 a=2 op=3", bus_a.issue_v, bus_a.wr_addr, bus_a.ALUop); end
    set_instr(XOR, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1);
    #1;
    n_checks++; if (bus_a.stalled !== 1'b0) begin n_fail++; $display("FAIL ind_xor_stalled got %0b exp 0", bus_a.stalled); end
    tick();
    n_checks++; if (bus_a.issue_v !== 1'b1 || bus_a.wr_addr !== 2'd0 || bus_a.ALUsrc1 !== takeIMM) begin n_fail++; $display("FAIL ind_xor_issue got v=%0b a=%0d s1=%0d exp v=1 a=0 s1=1", bus_a.issue_v, bus_a.wr_addr, bus_a.ALUsrc1); end
    set_instr(OUT, 2'd0, 2'd2, 1'b0, 2'd0, 1'b1);
    #1;
    n_checks++; if (bus_a.stalled !== 1'b1) begin n_fail++; $display("FAIL ind_out_raw_stalled got %0b exp 1", bus_a.stalled); end
    instv = 1'b0;
    tick();
    n_checks++; if (bus_a.issue_v !== 1'b0 || bus_a.ALUop !== XOR || bus_a.wr_addr !== 2'd0) begin n_fail++; $display("FAIL ind_idle_hold got v=%0b op=%0d a=%0d exp v=0 op=6 a=0", bus_a.issue_v, bus_a.ALUop, bus_a.wr_addr); end
  endtask

  task automatic test_raw_stall();
    int  stall_cnt = 0;
    bit  issued    = 0;
    logic f1 = 1'b1;
    logic [1:0] wa = '0;
    do_reset();
    set_instr(LD, 2'd1, 2'd0, 1'b1, 2'd0, 1'b1);
    tick();
    set_instr(ADD, 2'd2, 2'd1, 1'b0, 2'd0, 1'b0);
    for (int c = 0; c < 8 && !issued; c++) begin
      #1;
      if (bus_a.stalled === 1'b1) stall_cnt++;
      tick();
      if (bus_a.issue_v === 1'b1) begin issued = 1; f1 = bus_a.fwd1; wa = bus_a.wr_addr; end
    end
    instv = 1'b0;
    n_checks++; if (issued !== 1'b1) begin n_fail++; $display("FAIL raw_issued got %0b exp 1", issued); end
    n_checks++; if (stall_cnt != 3) begin n_fail++; $display("FAIL raw_stall_cycles got %0d exp 3", stall_cnt); end
    n_checks++; if (f1 !== 1'b0) begin n_fail++; $display("FAIL raw_fwd1 got %0b exp 0", f1); end
    n_checks++; if (wa !== 2'd2) begin n_fail++; $display("FAIL raw_wr_addr got %0d exp 2", wa); end
  endtask

  task automatic test_raw_bypass();
    int  stall_cnt = 0;
    bit  issued    = 0;
    logic f1 = 1'b0;
    logic f2 = 1'b1;
    do_reset();
    set_instr(LD, 2'd1, 2'd0, 1'b1, 2'd0, 1'b1);
    tick();
    set_instr(ADD, 2'd2, 2'd1, 1'b0, 2'd0, 1'b0);
    for (int c = 0; c < 8 && !issued; c++) begin
      #1;
      if (bus_b.stalled === 1'b1) stall_cnt++;
      tick();
      if (bus_b.issue_v === 1'b1) begin issued = 1; f1 = bus_b.fwd1; f2 = bus_b.fwd2; end
    end
    instv = 1'b0;
    n_checks++; if (issued !== 1'b1) begin n_fail++; $display("FAIL byp_issued got %0b exp 1", issued); end
    n_checks++; if (stall_cnt != 2) begin n_fail++; $display("FAIL byp_stall_cycles got %0d exp 2", stall_cnt); end
    n_checks++; if (f1 !== 1'b1) begin n_fail++; $display("FAIL byp_fwd1 got %0b exp 1", f1); end
    n_checks++; if (f2 !== 1'b0) begin n_fail++; $display("FAIL byp_fwd2 got %0b exp 0", f2); end
    tick();
    n_checks++; if (bus_b.fwd1 !== 1'b0 || bus_b.issue_v !== 1'b0) begin n_fail++; $display("FAIL byp_after_idle got f1=%0b v=%0b exp 0 0", bus_b.fwd1, bus_b.issue_v); end
  endtask

  task automatic test_illegal();
    t_opcode    ops [3] = '{LD, OUT, ADD};
    logic [1:0] dsts[3] = '{2'd1, 2'd0, 2'd3};
    logic       s1is[3] = '{1'b0, 1'b1, 1'b0};
    logic       ill, iv, st;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      set_instr(ops[k], dsts[k], 2'd0, s1is[k], 2'd0, 1'b1);
      #1;
      st = (k == 2) ? bus_c.stalled : bus_a.stalled;
      n_checks++; if (st !== 1'b0) begin n_fail++; $display("FAIL ill%0d_stalled got %0b exp 0", k, st); end
      tick();
      ill = (k == 2) ? bus_c.illegal : bus_a.illegal;
      iv  = (k == 2) ? bus_c.issue_v : bus_a.issue_v;
      n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL ill%0d_pulse got %0b exp 1", k, ill); end
      n_checks++; if (iv !== 1'b0) begin n_fail++; $display("FAIL ill%0d_issue_v got %0b exp 0", k, iv); end
      set_instr(ADD, 2'd2, 2'd1, 1'b0, 2'd0, 1'b1);
      #1;
      st = (k == 2) ? bus_c.stalled : bus_a.stalled;
      n_checks++; if (st !== 1'b0) begin n_fail++; $display("FAIL ill%0d_follow_stalled got %0b exp 0", k, st); end
      tick();
      ill = (k == 2) ? bus_c.illegal : bus_a.illegal;
      iv  = (k == 2) ? bus_c.issue_v : bus_a.issue_v;
      n_checks++; if (iv !== 1'b1 || ill !== 1'b0) begin n_fail++; $display("FAIL ill%0d_follow got v=%0b ill=%0b exp v=1 ill=0", k, iv, ill); end
      instv = 1'b0;
    end
  endtask

  task automatic test_mid_stall_reset();
    do_reset();
    set_instr(LD, 2'd1, 2'd0, 1'b1, 2'd0, 1'b1);
    tick();
    set_instr(ADD, 2'd2, 2'd1, 1'b0, 2'd0, 1'b0);
    #1;
    n_checks++; if (bus_a.issue_v !== 1'b1 || bus_a.stalled !== 1'b1) begin n_fail++; $display("FAIL mid_pre got v=%0b st=%0b exp 1 1", bus_a.issue_v, bus_a.stalled); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus_a.issue_v !== 1'b0 || bus_a.stalled !== 1'b0) begin n_fail++; $display("FAIL mid_async got v=%0b st=%0b exp 0 0", bus_a.issue_v, bus_a.stalled); end
    n_checks++; if (bus_a.internal_reset !== 1'b1) begin n_fail++; $display("FAIL mid_internal_reset got %0b exp 1", bus_a.internal_reset); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    n_checks++; if (bus_a.issue_v !== 1'b0) begin n_fail++; $display("FAIL mid_edge1_issue_v got %0b exp 0", bus_a.issue_v); end
    #1;
    n_checks++; if (bus_a.stalled !== 1'b0) begin n_fail++; $display("FAIL mid_sb_clear_stalled got %0b exp 0", bus_a.stalled); end
    tick();
    n_checks++; if (bus_a.issue_v !== 1'b1 || bus_a.wr_addr !== 2'd2 || bus_a.fwd1 !== 1'b0) begin n_fail++; $display("FAIL mid_reissue got v=%0b a=%0d f1=%0b exp 1 2 0", bus_a.issue_v, bus_a.wr_addr, bus_a.fwd1); end
    instv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw_stall();
    test_raw_bypass();
    test_illegal();
    test_mid_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Parametrised next-generation main controller for the pipelined microcontroller.
- Replaces the fixed "stall 3 cycles after every instruction" policy with a per-register scoreboard. Only true read-after-write hazards stall issue, with optional bypass.
- Decodes opcode and operand kinds into registered ALU/RF/output control signals for the EX stage, and flags illegal instructions.

Parameters:
- NUM_GPR, 4, number of general-purpose registers (≥2).
- PIPE_DEPTH, 3, cycles from issue until a result is readable from the RF (≥1).
- BYPASS_EN, 0, 1 = a source whose producer is exactly one cycle from RF write is forwarded instead of stalled.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  t_opcode  instruction opcode {LD,OUT,ADD,SUB,NAND,NOR,XOR,SHFL}
- instv  in  1  instruction valid; held stable by source while stalled=1
- dst  in  REG_W  destination GPR index
- src1  in  REG_W  source-1 GPR index (ignored if src1_imm)
- src1_imm  in  1  source 1 is immediate
- src2  in  REG_W  source-2 GPR index (ignored if src2_imm)
- src2_imm  in  1  source 2 is immediate
- internal_reset  out  1  pipeline flush toward downstream stages
- issue_v  out  1  registered: EX-stage controls valid this cycle
- ALUsrc1  out  t_ALUsrc_ctrl  takeGPR/takeIMM for ALU input 1
- ALUsrc2  out  t_ALUsrc_ctrl  takeGPR/takeIMM for ALU input 2
- ALUop  out  t_opcode  opcode forwarded to ALU
- wr_en  out  1  RF write enable for issued instruction
- wr_addr  out  REG_W  RF write index
- dataoutv  out  1  output data valid (OUT)
- fwd1  out  1  ALU input 1 takes bypass path
- fwd2  out  1  ALU input 2 takes bypass path
- stalled  out  1  combinational: valid instruction held by hazard
- illegal  out  1  registered one-cycle pulse: instruction dropped as illegal

REG_W = clog2(NUM_GPR).

Behaviour:
- Reset:
  - reset_n low asynchronously clears every scoreboard counter, issue_v, wr_en, dataoutv, fwd1, fwd2 and illegal, and drives ALUsrc1/2=takeGPR, ALUop=LD, wr_addr=0.
  - internal_reset=1 while reset_n low and for exactly one clock edge after release (synchronised deassertion).
  - No instruction is accepted while internal_reset=1.
- Scoreboard:
  - busy[r] per GPR, width clog2(PIPE_DEPTH+1).
  - Each edge: nonzero counters decrement by 1.
  - On accept of a writing instruction (LD, ALU ops) busy[dst] loads PIPE_DEPTH. Load beats decrement on the same edge.
  - Write-after-write to a pending register simply reloads the counter.
- Hazard for source k (GPR, not imm):
  - BYPASS_EN=0: hazard if busy[srck]≠0.
  - BYPASS_EN=1: hazard if busy[srck]>1. If busy[srck]==1, no hazard and fwdk is set with the issued controls.
- Legality (checked before hazard):
  - Illegal: LD with src1_imm=0; OUT with src1_imm=1; any GPR index ≥ NUM_GPR (dst for writers, srcs used); opcode outside the enum.
  - Illegal instruction: consumed in one cycle, not stalled, no scoreboard change, illegal=1 next cycle.
- Operand use:
  - LD uses src1 only.
  - OUT uses src1 only.
  - ALU ops use src1 and src2.
  - Unused sources never cause hazards.
- Accept: instv & legal & ~hazard & ~internal_reset. Next cycle the registered outputs present:
  - issue_v=1
  - decoded ALUsrc1/2
  - ALUop=opcode
  - wr_en=1 for LD/ALU ops
  - wr_addr=dst
  - dataoutv=1 for OUT
  - fwd1/fwd2
- stalled = instv & legal & hazard & ~internal_reset. While stalled, issue_v=0 next cycle.
- Non-accept cycles: issue_v, wr_en, dataoutv, fwd1, fwd2=0. ALUsrc/ALUop/wr_addr hold their last values.
- Throughput and latency:
  - Independent instructions issue back-to-back, 1 per cycle.
  - Control latency is 1 cycle from accept.
  - Dependent stall is PIPE_DEPTH cycles, or PIPE_DEPTH−1 with bypass.
- Reset asserted mid-stall: pending instruction and scoreboard discarded. After release, the source re-presents it.

Decomposition:
- Shared package definitions holds:
  - existing t_opcode and t_ALUsrc_ctrl
  - t_reg_name extended with a helper function is_gpr_idx(idx, NUM_GPR)
  - a constant localparam for the default PIPE_DEPTH
- One sub-module, reg_scoreboard: parameters NUM_GPR and PIPE_DEPTH. Load port (en, idx). Two read ports returning busy and "last cycle" flags.
- Decode, legality and output registers stay in hazard_controller.

Test Plan:
- Reset release: reset_n 0→1 at edge 0 → internal_reset=1 through edge 1. An instruction presented at edge 1 is not accepted; it is accepted at edge 2.
- Independent stream: ADD R1←R0,IMM; SUB R2←R3,IMM; XOR R0←IMM,IMM on consecutive cycles → issue_v=1 three consecutive cycles, stalled=0, wr_addr 1,2,0.
- RAW stall, BYPASS_EN=0, PIPE_DEPTH=3: LD R1←IMM, then ADD R2←R1,R0 → stalled=1 for 3 cycles. ADD issues on cycle 4 with fwd1=0.
- RAW with bypass, BYPASS_EN=1: same sequence → stalled=1 for 2 cycles. ADD issues with fwd1=1, fwd2=0.
- Illegal: LD with src1_imm=0; OUT with src1_imm=1; NUM_GPR=3 with dst=3 → each gives illegal=1 one cycle, issue_v=0, no stall, no scoreboard change. A following ADD reading that dst issues immediately.
- Mid-stall reset: during the stall of the RAW scenario, pull reset_n low asynchronously → issue_v/stalled drop without a clock. After release the scoreboard is clear, and the re-presented ADD issues without stall.
